// File: rtl/video_timing_gen.sv
// Raster timing generator: frame-aligned run/stop FSM, h/v counters, a registered
// fetch stage and a FETCH_LEAD-deep display pipeline.
module video_timing_gen #(
  parameter int H_ACTIVE   = 1366,
  parameter int H_BLANK    = 50,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 24,
  parameter int V_ACTIVE   = 768,
  parameter int V_BLANK    = 12,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 4,
  parameter int FETCH_LEAD = 2
) (
  input  logic        DotClock,
  input  logic        rst,
  input  logic        run,
  output logic        FetchEn,
  output logic [10:0] FetchX,
  output logic [10:0] FetchY,
  output logic        HSync,
  output logic        VSync,
  output logic        DataEnable,
  output logic [10:0] PixelX,
  output logic [10:0] PixelY,
  output logic        FrameStart,
  output logic        busy
);

  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_BLANK - 1);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_BLANK - 1);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic        hs_n;
    logic        vs_n;
    logic        en;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
  } tap_t;

  localparam tap_t TAP_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, en: 1'b0, x: 11'd0, y: 11'd0, fs: 1'b0};

  state_t      state_q, state_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  tap_t        fetch_q, fetch_d;
  tap_t        pipe_q [FETCH_LEAD];
  logic        active;
  logic        frame_last;

  assign frame_last = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

  always_ff @(posedge DotClock) begin
    if (rst) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      fetch_q <= TAP_IDLE;
      for (int i = 0; i < FETCH_LEAD; i++) pipe_q[i] <= TAP_IDLE;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      fetch_q   <= fetch_d;
      pipe_q[0] <= fetch_q;
      for (int i = 1; i < FETCH_LEAD; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Stopping is only ever granted at the last pixel of a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_RUN;
      S_RUN:   if (!run) state_d = S_DRAIN;
      S_DRAIN: begin
        if (run)             state_d = S_RUN;
        else if (frame_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    active = (state_q != S_IDLE);
    busy   = active;
  end

  // The natural wrap at the last pixel already yields (0,0) on the DRAIN->IDLE edge.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!active) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? 11'd0 : vcnt_q + 11'd1;
    end else begin
      hcnt_d = hcnt_q + 11'd1;
    end
  end

  always_comb begin
    fetch_d.en   = active && (hcnt_q < HA) && (vcnt_q < VA);
    fetch_d.x    = hcnt_q;
    fetch_d.y    = vcnt_q;
    fetch_d.hs_n = !(active && (hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    fetch_d.vs_n = !(active && (vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    fetch_d.fs   = active && (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
  end

  assign FetchEn    = fetch_q.en;
  assign FetchX     = fetch_q.x;
  assign FetchY     = fetch_q.y;
  assign HSync      = pipe_q[FETCH_LEAD-1].hs_n;
  assign VSync      = pipe_q[FETCH_LEAD-1].vs_n;
  assign DataEnable = pipe_q[FETCH_LEAD-1].en;
  assign PixelX     = pipe_q[FETCH_LEAD-1].x;
  assign PixelY     = pipe_q[FETCH_LEAD-1].y;
  assign FrameStart = pipe_q[FETCH_LEAD-1].fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster (24x10 total, 16x6 active, lead 4):
// frame-position model checked every cycle plus directed literal timing checks.
module tb_video_timing_gen;
  localparam int HA = 16, HB = 8, HFP = 2, HS = 3;
  localparam int VA = 6,  VB = 4, VFP = 1, VS = 2;
  localparam int LEAD = 4;
  localparam int HT = HA + HB;
  localparam int VT = VA + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        en;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
  } tup_t;

  logic        clk = 1'b0;
  logic        rst, run;
  logic        FetchEn, HSync, VSync, DataEnable, FrameStart, busy;
  logic [10:0] FetchX, FetchY, PixelX, PixelY;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .H_FP(HFP), .H_SYNC(HS),
    .V_ACTIVE(VA), .V_BLANK(VB), .V_FP(VFP), .V_SYNC(VS),
    .FETCH_LEAD(LEAD)
  ) dut (
    .DotClock(clk), .rst(rst), .run(run),
    .FetchEn(FetchEn), .FetchX(FetchX), .FetchY(FetchY),
    .HSync(HSync), .VSync(VSync), .DataEnable(DataEnable),
    .PixelX(PixelX), .PixelY(PixelY), .FrameStart(FrameStart),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // Model: position within the frame plus a busy flag; display = fetch delayed LEAD cycles.
  localparam tup_t T_IDLE = '{hs: 1'b1, vs: 1'b1, en: 1'b0, x: 11'd0, y: 11'd0, fs: 1'b0};
  tup_t exp_f, exp_d, f;
  tup_t dq[$];
  bit   busy_m, prev_run, chk_on;
  int   pos, h, v;

  initial begin
    busy_m = 0; prev_run = 0; chk_on = 0; pos = 0;
    exp_f = T_IDLE; exp_d = T_IDLE;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      chk_on = 1; busy_m = 0; pos = 0; prev_run = 0;
      dq.delete();
      for (int i = 0; i < LEAD; i++) dq.push_back(T_IDLE);
      exp_f = T_IDLE; exp_d = T_IDLE;
    end else if (chk_on) begin
      h = pos % HT;
      v = pos / HT;
      f.en = busy_m && h < HA && v < VA;
      f.x  = 11'(h);
      f.y  = 11'(v);
      f.hs = !(busy_m && h >= HA + HFP && h < HA + HFP + HS);
      f.vs = !(busy_m && v >= VA + VFP && v < VA + VFP + VS);
      f.fs = busy_m && pos == 0;
      exp_f = f;
      dq.push_back(f);
      exp_d = dq.pop_front();
      if (!busy_m) begin
        busy_m = run;
        pos = 0;
      end else if (pos == FRAME - 1 && !run && !prev_run) begin
        busy_m = 0;
        pos = 0;
      end else begin
        pos = (pos + 1) % FRAME;
      end
      prev_run = run;
    end
  end

  // Synchronous source with LEAD-cycle latency returning the fetched column.
  logic [10:0] ram_q [LEAD];
  always @(posedge clk) begin
    ram_q[0] <= FetchEn ? FetchX : 11'h7ff;
    for (int i = 1; i < LEAD; i++) ram_q[i] <= ram_q[i-1];
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, busy_m);
      chk("fetch", {FetchEn, FetchX, FetchY}, {exp_f.en, exp_f.x, exp_f.y});
      chk("display", {HSync, VSync, DataEnable, PixelX, PixelY, FrameStart}, exp_d);
      if (DataEnable) chk("ram_align", ram_q[LEAD-1], PixelX);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_y(input int y);
    int n = 0;
    while (PixelY != 11'(y) && n < 400) begin step(1); n++; end
    chk("wait_y_timeout", n < 400, 1);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin step(1); n++; end while (!FrameStart && n < 400);
    chk("wait_fs_timeout", FrameStart, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin step(1); n++; end
    chk("wait_idle_timeout", busy, 0);
  endtask

  int cnt, de_cnt, de_line, fs_cnt, vs_low, vs_first, hs_low, hs_first, t0;

  initial begin
    rst = 1; run = 0;
    step(3);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_hsync", HSync, 1);
    chk("rst_vsync", VSync, 1);
    chk("rst_de", DataEnable, 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin step(1); if (FetchEn) cnt++; end
    chk("idle_no_fetch", cnt, 0);

    run = 1;
    step(1);
    chk("start_busy", busy, 1);
    chk("start_fe_k", FetchEn, 0);
    step(1);
    chk("start_fe_k1", FetchEn, 1);
    chk("start_fx", FetchX, 0);
    chk("start_fy", FetchY, 0);
    chk("start_de_k1", DataEnable, 0);
    step(3);
    chk("start_de_k4", DataEnable, 0);
    step(1);
    chk("start_de_k5", DataEnable, 1);
    chk("start_fs_k5", FrameStart, 1);
    chk("start_px", PixelX, 0);
    chk("start_py", PixelY, 0);

    de_cnt = 0; de_line = 0; fs_cnt = 0; vs_low = 0; vs_first = -1; hs_low = 0; hs_first = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (DataEnable) de_cnt++;
      if (FrameStart) fs_cnt++;
      if (!VSync) begin vs_low++; if (vs_first < 0) vs_first = PixelY; end
      if (i < HT && DataEnable) de_line++;
      if (i < HT && !HSync) begin hs_low++; if (hs_first < 0) hs_first = PixelX; end
      step(1);
    end
    chk("frame_period_fs", FrameStart, 1);
    chk("frame_de_count", de_cnt, 96);
    chk("frame_fs_count", fs_cnt, 1);
    chk("frame_vs_low", vs_low, 48);
    chk("frame_vs_first_y", vs_first, 7);
    chk("line_de_count", de_line, 16);
    chk("line_hs_low", hs_low, 3);
    chk("line_hs_first_x", hs_first, 18);

    wait_y(2);
    run = 0;
    wait_idle();
    chk("stop_last_fx", FetchX, 23);
    chk("stop_last_fy", FetchY, 9);
    fs_cnt = 0;
    for (int i = 0; i < 100; i++) begin step(1); if (FrameStart) fs_cnt++; end
    chk("stop_no_fs", fs_cnt, 0);
    chk("stop_de_idle", DataEnable, 0);

    run = 1;
    wait_fs();
    t0 = cyc;
    wait_y(2);
    run = 0;
    wait_y(5);
    run = 1;
    wait_fs();
    chk("restart_period", cyc - t0, FRAME);
    chk("restart_busy", busy, 1);

    step(30);
    rst = 1;
    step(1);
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_fe", FetchEn, 0);
    chk("midrst_de", DataEnable, 0);
    step(20);
    run = 0;
    wait_idle();
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
